stage_bus_fifo: RTL and testbench

- Parametrised successor to the single-slot fetch-to-decode bus between two adjacent pipeline stages (fetch->decode, decode->execute, etc.).
- Holds up to DEPTH packets of WIDTH bits in a circular buffer.
- Uses a valid/ready handshake on both sides and adds occupancy reporting, an almost-full hint for the producer, a pipeline flush and sticky protocol-error flags.
- Replaces the single is_busy slot, which forced the producer to stall every other cycle.

---
 rtl/stage_bus_fifo.sv | 127 ++++++++++++
 tb/tb_stage_bus_fifo.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/stage_bus_fifo.sv
// Valid/ready packet FIFO between adjacent pipeline stages, with occupancy,
// almost-full hint, flush and sticky protocol-error flags. Optional
// empty-FIFO pass-through is enabled by defining STAGE_BUS_FIFO_BYPASS_EN.
module stage_bus_fifo #(
  parameter int WIDTH             = 64,
  parameter int DEPTH             = 4,
  parameter int ALMOST_FULL_LEVEL = DEPTH - 1,
  parameter bit ASSERT_EN         = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       send_valid,
  output logic                       send_ready,
  input  logic [WIDTH-1:0]           send_data,
  output logic                       recv_valid,
  input  logic                       recv_ready,
  output logic [WIDTH-1:0]           recv_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       almost_full,
  output logic                       overflow_err,
  output logic                       underflow_err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(ALMOST_FULL_LEVEL);

  // Handshake: a side transfers on a rising edge only when its valid and
  // ready are both high and flush is low. send_ready depends on occupancy
  // only (never on recv_ready); recv_valid never depends on recv_ready.

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             empty;
  logic             bypass;
  logic             bypass_take;
  logic             push;
  logic             pop;

  assign empty      = (count == '0);
  assign send_ready = (count < FULL_CNT);

`ifdef STAGE_BUS_FIFO_BYPASS_EN
  // An empty FIFO presents the incoming packet directly; flush suppresses it.
  assign bypass      = empty && send_valid && !flush;
  assign bypass_take = bypass && recv_ready;
  assign recv_valid  = !empty || bypass;
  assign recv_data   = bypass ? send_data : mem[rd_ptr];
`else
  assign bypass      = 1'b0;
  assign bypass_take = 1'b0;
  assign recv_valid  = !empty;
  assign recv_data   = mem[rd_ptr];
`endif

  assign push = send_valid && send_ready && !flush && !bypass_take;
  assign pop  = !empty && recv_ready && !flush;

  assign almost_full = (count >= AF_CNT);

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Storage is deliberately left unreset; only pointers and count qualify it.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= send_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Protocol violations latch until reset; flush neither sets nor clears them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      if (send_valid && !send_ready) begin
        overflow_err <= 1'b1;
      end
      if (recv_ready && !recv_valid) begin
        underflow_err <= 1'b1;
      end
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (ASSERT_EN && !reset) begin
      assert (!(send_valid && !send_ready))
        else $error("stage_bus_fifo: send_valid while send_ready is low");
      assert (!(recv_ready && !recv_valid))
        else $error("stage_bus_fifo: recv_ready while recv_valid is low");
    end
  end
`endif

endmodule

// File: tb/tb_stage_bus_fifo.sv
// Bench for stage_bus_fifo: directed plan steps followed by random traffic,
// each cycle compared against a queue-based model of the FIFO contract.
module tb_stage_bus_fifo;

  localparam int W   = 64;
  localparam int D   = 4;
  localparam int AFL = 3;
  localparam int CW  = $clog2(D + 1);

  logic          clk;
  logic          reset;
  logic          flush;
  logic          send_valid;
  logic          send_ready;
  logic [W-1:0]  send_data;
  logic          recv_valid;
  logic          recv_ready;
  logic [W-1:0]  recv_data;
  logic [CW-1:0] count;
  logic          almost_full;
  logic          overflow_err;
  logic          underflow_err;

  int errors;
  int checks;

  // Reference model state
  logic [W-1:0] exp_q[$];
  logic         m_ovf;
  logic         m_unf;

  stage_bus_fifo #(
    .WIDTH(W),
    .DEPTH(D),
    .ALMOST_FULL_LEVEL(AFL),
    .ASSERT_EN(1'b0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .flush(flush),
    .send_valid(send_valid),
    .send_ready(send_ready),
    .send_data(send_data),
    .recv_valid(recv_valid),
    .recv_ready(recv_ready),
    .recv_data(recv_data),
    .count(count),
    .almost_full(almost_full),
    .overflow_err(overflow_err),
    .underflow_err(underflow_err)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // Driver + scoreboard step: call just after a rising edge. Outputs are
  // compared at the falling edge, then the model takes the rising edge.
  task automatic step(input logic sv, input logic [W-1:0] sd, input logic rr, input logic fl);
    int  n;
    bit  e_sr;
    bit  e_rv;
    bit  byp;
    logic [W-1:0] e_rd;
    send_valid = sv;
    send_data  = sd;
    recv_ready = rr;
    flush      = fl;
    @(negedge clk);
    n    = exp_q.size();
    e_sr = (n < D);
`ifdef STAGE_BUS_FIFO_BYPASS_EN
    byp = (n == 0) && sv && !fl;
`else
    byp = 1'b0;
`endif
    e_rv = (n > 0) || byp;
    e_rd = byp ? sd : ((n > 0) ? exp_q[0] : '0);
    chk("send_ready", W'(send_ready), W'(e_sr));
    chk("recv_valid", W'(recv_valid), W'(e_rv));
    chk("count", W'(count), W'(n));
    chk("almost_full", W'(almost_full), W'(n >= AFL));
    chk("overflow_err", W'(overflow_err), W'(m_ovf));
    chk("underflow_err", W'(underflow_err), W'(m_unf));
    if (e_rv) chk("recv_data", recv_data, e_rd);
    @(posedge clk);
    if (sv && !e_sr) m_ovf = 1'b1;
    if (rr && !e_rv) m_unf = 1'b1;
    if (fl) begin
      exp_q.delete();
    end else if (!(byp && rr)) begin
      if (rr && n > 0) void'(exp_q.pop_front());
      if (sv && n < D) exp_q.push_back(sd);
    end
    #1;
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    errors     = 0;
    checks     = 0;
    reset      = 1'b1;
    flush      = 1'b0;
    send_valid = 1'b0;
    send_data  = '0;
    recv_ready = 1'b0;
    model_reset();

    // Reset state
    #2;
    chk("rst_count", W'(count), '0);
    chk("rst_send_ready", W'(send_ready), W'(1));
    chk("rst_recv_valid", W'(recv_valid), '0);
    chk("rst_almost_full", W'(almost_full), '0);
    chk("rst_ovf", W'(overflow_err), '0);
    chk("rst_unf", W'(underflow_err), '0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Fill A1..A4, overflow with EE, drain in order, then underflow
    for (int i = 1; i <= 4; i++) step(1'b1, W'(8'hA0 + i), 1'b0, 1'b0);
    step(1'b1, W'(8'hEE), 1'b0, 1'b0);
    idle();
    chk("full_count", W'(count), W'(4));
    chk("full_ovf_sticky", W'(overflow_err), W'(1));
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    idle();
    chk("empty_unf_sticky", W'(underflow_err), W'(1));
    chk("empty_ovf_sticky", W'(overflow_err), W'(1));

    // Asynchronous reset mid-cycle with two entries held
    step(1'b1, W'(16'h0B01), 1'b0, 1'b0);
    step(1'b1, W'(16'h0B02), 1'b0, 1'b0);
    #3 reset = 1'b1;
    #1;
    chk("async_count", W'(count), '0);
    chk("async_recv_valid", W'(recv_valid), '0);
    chk("async_flags", W'({overflow_err, underflow_err}), '0);
    model_reset();
    send_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;

    // Continuous stream of 12 packets, then drain
    for (int i = 0; i < 12; i++) step(1'b1, W'(16'h0100 + i), 1'b1, 1'b0);
    repeat (2) step(1'b0, '0, 1'b1, 1'b0);

    // Flush with three held and 0x55 offered
    for (int i = 0; i < 3; i++) step(1'b1, W'(16'h0C00 + i), 1'b0, 1'b0);
    step(1'b1, W'(8'h55), 1'b0, 1'b1);
    chk("flush_count", W'(count), '0);
    chk("flush_recv_valid", W'(recv_valid), '0);
    idle();

    // Empty FIFO, send 0x77 with recv_ready high
    step(1'b1, W'(8'h77), 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, {$urandom, $urandom},
           $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0);
    end

    // Flags clear only on reset
    reset = 1'b1;
    #1;
    model_reset();
    chk("final_flags", W'({overflow_err, underflow_err}), '0);
    chk("final_count", W'(count), '0);
    @(posedge clk);
    #1 reset = 1'b0;
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
